voxel_gpu_sequencer: RTL and testbench

Command-queue front end for the voxel GPU shader array. It replaces single-shot register-triggered operations with a parametrised command FIFO, a dispatch FSM with a watchdog, and an autonomous burst write-back of a whole shader span to the framebuffer. It sits between the Avalon-MM CSR slave (s1), the shader array (op_* / pix_* handshake) and the framebuffer Avalon-MM master (m1).

---
 rtl/voxel_gpu_sequencer_if.sv | 45 ++++
 rtl/voxel_gpu_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_voxel_gpu_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voxel_gpu_sequencer_if.sv
// Bus bundle for the voxel GPU sequencer: CSR slave (s1), framebuffer master (m1)
// and the shader-array dispatch / pixel read-back handshake.
interface voxel_gpu_sequencer_if #(
    parameter int PIXEL_BITS = 16,
    parameter int INDEX_BITS = 8
);
    logic [7:0]            s1_address;
    logic                  s1_read;
    logic                  s1_write;
    logic [31:0]           s1_writedata;
    logic [31:0]           s1_readdata;
    logic                  s1_waitrequest;
    logic                  irq;

    logic [31:0]           m1_address;
    logic [PIXEL_BITS-1:0] m1_writedata;
    logic                  m1_write;
    logic                  m1_waitrequest;

    logic                  op_start;
    logic [1:0]            op_code;
    logic [31:0]           op_arg;
    logic                  op_done;
    logic                  op_error;
    logic [INDEX_BITS-1:0] pix_index;
    logic [PIXEL_BITS-1:0] pix_data;

    modport slave (
        input  s1_address, s1_read, s1_write, s1_writedata,
        output s1_readdata, s1_waitrequest, irq,
        output m1_address, m1_writedata, m1_write,
        input  m1_waitrequest,
        output op_start, op_code, op_arg, pix_index,
        input  op_done, op_error, pix_data
    );

    modport master (
        output s1_address, s1_read, s1_write, s1_writedata,
        input  s1_readdata, s1_waitrequest, irq,
        input  m1_address, m1_writedata, m1_write,
        output m1_waitrequest,
        input  op_start, op_code, op_arg, pix_index,
        output op_done, op_error, pix_data
    );
endinterface

// File: rtl/voxel_gpu_sequencer.sv
// Command-queue front end for the voxel GPU: CSR-fed command FIFO, dispatch FSM
// with watchdog, and burst write-back of one shader span to the framebuffer.
module voxel_gpu_sequencer #(
    parameter int H_RESOLUTION   = 320,
    parameter int V_RESOLUTION   = 240,
    parameter int NUM_SHADERS    = 200,
    parameter int PIXEL_BITS     = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic             clock,
    input logic             reset_n,
    voxel_gpu_sequencer_if.slave bus
);
    localparam int TOTAL_PIXELS = H_RESOLUTION * V_RESOLUTION;
    localparam int PIXEL_BYTES  = PIXEL_BITS / 8;
    localparam int INDEX_BITS   = $clog2(NUM_SHADERS);
    localparam int COUNT_BITS   = INDEX_BITS + 1;
    localparam int PTR_BITS     = $clog2(FIFO_DEPTH);
    localparam int WD_BITS      = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITEBACK, ERROR} state_t;

    state_t state, state_next;

    logic [1:0]            fifo_op  [FIFO_DEPTH];
    logic [31:0]           fifo_arg [FIFO_DEPTH];
    logic [PTR_BITS:0]     wr_ptr, rd_ptr, level;
    logic                  fifo_full, fifo_empty;
    logic [1:0]            head_op;
    logic [31:0]           head_arg;

    logic                  csr_push, ctrl_write, clear_err, status_read;
    logic                  pop, push_ok, overflow;
    logic                  fault, complete, wd_clear, wd_inc, wb_advance;
    logic [1:0]            fault_code;
    logic                  enter_error, done_set;

    logic [1:0]            cur_op;
    logic [31:0]           cur_arg;
    logic [31:0]           wb_base;
    logic [COUNT_BITS-1:0] wb_count;
    logic [INDEX_BITS-1:0] wb_k;
    logic [WD_BITS-1:0]    wd;
    logic [31:0]           start_pixel;
    logic [31:0]           cmd_count;
    logic [1:0]            err_code;
    logic                  irq_en;
    logic                  done_pending;
    logic [31:0]           remaining;
    logic [COUNT_BITS-1:0] span_count;
    logic [31:0]           status_word;
    logic                  wb_active;

    assign level      = wr_ptr - rd_ptr;
    assign fifo_full  = (level == (PTR_BITS+1)'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign head_op    = fifo_op[rd_ptr[PTR_BITS-1:0]];
    assign head_arg   = fifo_arg[rd_ptr[PTR_BITS-1:0]];

    assign csr_push    = bus.s1_write && (bus.s1_address[7:2] == 6'd0);
    assign ctrl_write  = bus.s1_write && (bus.s1_address == 8'h0e);
    assign clear_err   = ctrl_write && bus.s1_writedata[0];
    assign status_read = bus.s1_read && (bus.s1_address == 8'h0f);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign pop      = (state == IDLE) && !fifo_empty && !clear_err;
    assign push_ok  = csr_push && !clear_err && (!fifo_full || pop);
    assign overflow = csr_push && fifo_full && !pop && (state != ERROR);

    // Span length is clipped so the burst never runs past the last screen pixel
    assign remaining  = (start_pixel >= 32'(TOTAL_PIXELS)) ? 32'd0 : 32'(TOTAL_PIXELS) - start_pixel;
    assign span_count = (remaining > 32'(NUM_SHADERS)) ? COUNT_BITS'(NUM_SHADERS) : COUNT_BITS'(remaining);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_err) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (PTR_BITS+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (PTR_BITS+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_op[wr_ptr[PTR_BITS-1:0]]  <= bus.s1_address[1:0];
            fifo_arg[wr_ptr[PTR_BITS-1:0]] <= bus.s1_writedata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        fault      = 1'b0;
        fault_code = 2'd0;
        complete   = 1'b0;
        wd_clear   = 1'b0;
        wd_inc     = 1'b0;
        wb_advance = 1'b0;
        case (state)
            IDLE: begin
                if (pop) state_next = (head_op == 2'd2) ? WRITEBACK : ISSUE;
            end
            ISSUE: begin
                state_next = WAIT;
                wd_clear   = 1'b1;
            end
            WAIT: begin
                if (bus.op_error) begin
                    fault      = 1'b1;
                    fault_code = 2'd1;
                end else if (bus.op_done) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (wd == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
                    fault      = 1'b1;
                    fault_code = 2'd3;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            WRITEBACK: begin
                if (wb_count == '0) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (!bus.m1_waitrequest) begin
                    wd_clear = 1'b1;
                    if ({1'b0, wb_k} == wb_count - COUNT_BITS'(1)) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        wb_advance = 1'b1;
                    end
                end else if (wd == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
                    fault      = 1'b1;
                    fault_code = 2'd3;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            ERROR: state_next = ERROR;
            default: state_next = IDLE;
        endcase
        if (fault) state_next = ERROR;
        if (overflow) begin
            state_next = ERROR;
            fault_code = 2'd2;
        end
        if (clear_err) state_next = IDLE;
    end

    assign enter_error = (state_next == ERROR) && (state != ERROR);
    assign done_set    = enter_error ||
                         (complete && (state_next == IDLE) && fifo_empty && !push_ok);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_op       <= 2'd0;
            cur_arg      <= '0;
            wb_base      <= '0;
            wb_count     <= '0;
            wb_k         <= '0;
            wd           <= '0;
            start_pixel  <= '0;
            cmd_count    <= '0;
            err_code     <= 2'd0;
            irq_en       <= 1'b0;
            done_pending <= 1'b0;
        end else begin
            if (pop) begin
                cur_op  <= head_op;
                cur_arg <= head_arg;
                if (head_op == 2'd3) start_pixel <= head_arg;
                if (head_op == 2'd2) begin
                    wb_base  <= head_arg;
                    wb_count <= span_count;
                    wb_k     <= '0;
                end
            end
            if (wb_advance) wb_k <= wb_k + INDEX_BITS'(1);
            if (wd_clear || pop) wd <= '0;
            else if (wd_inc)     wd <= wd + WD_BITS'(1);
            if (complete) cmd_count <= cmd_count + 32'd1;
            if (clear_err)        err_code <= 2'd0;
            else if (enter_error) err_code <= fault_code;
            if (ctrl_write) irq_en <= bus.s1_writedata[1];
            if (done_set)         done_pending <= 1'b1;
            else if (status_read) done_pending <= 1'b0;
        end
    end

    assign status_word = {15'd0, done_pending, 8'(level), 4'd0, err_code,
                          (state == ERROR), ((state != IDLE) || !fifo_empty)};

    always_comb begin
        bus.s1_readdata = '0;
        case (bus.s1_address)
            8'h0f:   bus.s1_readdata = status_word;
            8'h10:   bus.s1_readdata = cmd_count;
            8'h11:   bus.s1_readdata = start_pixel;
            default: bus.s1_readdata = '0;
        endcase
    end

    // Burst outputs decode straight from state so an async reset drops m1_write at once
    assign wb_active          = (state == WRITEBACK) && (wb_count != '0);
    assign bus.m1_write       = wb_active;
    assign bus.m1_address     = wb_active ? wb_base + (start_pixel + 32'(wb_k)) * 32'(PIXEL_BYTES) : '0;
    assign bus.m1_writedata   = wb_active ? bus.pix_data : '0;
    assign bus.pix_index      = wb_active ? wb_k : '0;

    assign bus.op_start       = (state == ISSUE);
    assign bus.op_code        = (state == ISSUE) ? cur_op : 2'd0;
    assign bus.op_arg         = (state == ISSUE) ? cur_arg : '0;

    assign bus.s1_waitrequest = 1'b0;
    assign bus.irq            = irq_en && (done_pending || (state == ERROR));
endmodule

// File: tb/tb_voxel_gpu_sequencer.sv
// Directed self-checking bench for voxel_gpu_sequencer: dispatch, span write-back,
// overflow, watchdog, op_error priority and asynchronous reset mid-burst.
module tb_voxel_gpu_sequencer;
    logic clock;
    logic reset_n;

    voxel_gpu_sequencer_if #(.PIXEL_BITS(16), .INDEX_BITS(8)) bus ();

    voxel_gpu_sequencer #(
        .H_RESOLUTION(320), .V_RESOLUTION(240), .NUM_SHADERS(200),
        .PIXEL_BITS(16), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    int          compared = 0;
    int          mismatched = 0;
    logic        auto_done;
    int          done_delay;
    logic        resp_done;
    logic        man_done;
    int          beat;
    int          stall_left;
    int          bursts_done;
    int          last_beats;
    logic        prev_write;
    logic [31:0] exp_base;
    logic [31:0] exp_sp;
    logic [31:0] first_addr;
    logic [31:0] last_addr;
    logic [31:0] rd;

    assign bus.op_done  = resp_done | man_done;
    assign bus.pix_data = 16'hA000 ^ {8'h00, bus.pix_index};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clock);
        bus.s1_address   = addr;
        bus.s1_writedata = data;
        bus.s1_write     = 1'b1;
        @(negedge clock);
        bus.s1_write     = 1'b0;
        bus.s1_address   = 8'h00;
        bus.s1_writedata = 32'h0;
    endtask

    task automatic readRegister(input logic [7:0] addr, output logic [31:0] data);
        @(negedge clock);
        bus.s1_address = addr;
        bus.s1_read    = 1'b1;
        #1 data = bus.s1_readdata;
        @(negedge clock);
        bus.s1_read    = 1'b0;
        bus.s1_address = 8'h00;
    endtask

    task automatic waitBurst(input string tag, input int limit);
        int start_count;
        int n;
        start_count = bursts_done;
        n = 0;
        while (bursts_done == start_count && n < limit) begin
            @(negedge clock);
            n++;
        end
        checkOutput({tag, "_finished"}, 32'(bursts_done - start_count), 32'd1);
    endtask

    // Shader model: answers each dispatch with op_done after done_delay cycles
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.op_start && auto_done) begin
                repeat (done_delay) @(negedge clock);
                resp_done = 1'b1;
                @(negedge clock);
                resp_done = 1'b0;
            end
        end
    end

    // Framebuffer model: checks every presented beat and stalls beats 0, 50 and 199
    initial begin
        beat = 0;
        stall_left = 0;
        bursts_done = 0;
        last_beats = 0;
        prev_write = 1'b0;
        first_addr = 32'h0;
        last_addr = 32'h0;
        bus.m1_waitrequest = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.m1_write) begin
                if (!prev_write) begin
                    beat = 0;
                    stall_left = 2;
                    first_addr = bus.m1_address;
                end
                checkOutput("wb_addr", bus.m1_address, exp_base + (exp_sp + 32'(beat)) * 32'd2);
                checkOutput("wb_data", 32'(bus.m1_writedata), 32'(16'hA000 ^ 16'(beat)));
                checkOutput("wb_index", 32'(bus.pix_index), 32'(beat));
                last_addr = bus.m1_address;
                if (stall_left > 0) begin
                    bus.m1_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    bus.m1_waitrequest = 1'b0;
                    beat++;
                    stall_left = (beat == 50 || beat == 199) ? 2 : 0;
                end
            end else begin
                if (prev_write) begin
                    bursts_done++;
                    last_beats = beat;
                end
                bus.m1_waitrequest = 1'b0;
            end
            prev_write = bus.m1_write;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        reset_n          = 1'b0;
        bus.s1_address   = 8'h00;
        bus.s1_read      = 1'b0;
        bus.s1_write     = 1'b0;
        bus.s1_writedata = 32'h0;
        bus.op_error     = 1'b0;
        man_done         = 1'b0;
        auto_done        = 1'b0;
        done_delay       = 5;
        exp_base         = 32'h0;
        exp_sp           = 32'h0;

        repeat (3) @(negedge clock);
        checkOutput("rst_m1_write", 32'(bus.m1_write), 32'd0);
        checkOutput("rst_op_start", 32'(bus.op_start), 32'd0);
        checkOutput("rst_irq", 32'(bus.irq), 32'd0);
        reset_n = 1'b1;
        readRegister(8'h0f, rd);
        checkOutput("rst_status", rd, 32'h0);
        readRegister(8'h10, rd);
        checkOutput("rst_counter", rd, 32'h0);

        $display("[TB] rasterize dispatch");
        auto_done = 1'b1;
        applyStimulus(8'h00, 32'h0000_1234);
        checkOutput("ras_start_early", 32'(bus.op_start), 32'd0);
        @(negedge clock);
        checkOutput("ras_start", 32'(bus.op_start), 32'd1);
        checkOutput("ras_code", 32'(bus.op_code), 32'd0);
        checkOutput("ras_arg", bus.op_arg, 32'h0000_1234);
        @(negedge clock);
        checkOutput("ras_start_pulse", 32'(bus.op_start), 32'd0);
        repeat (10) @(negedge clock);
        checkOutput("ras_irq_disabled", 32'(bus.irq), 32'd0);
        applyStimulus(8'h0e, 32'h2);
        checkOutput("ras_irq_enabled", 32'(bus.irq), 32'd1);
        readRegister(8'h0f, rd);
        checkOutput("ras_status", rd, 32'h0001_0000);
        checkOutput("ras_irq_cleared", 32'(bus.irq), 32'd0);
        readRegister(8'h10, rd);
        checkOutput("ras_counter", rd, 32'd1);

        $display("[TB] span write-back from pixel 200");
        done_delay = 3;
        exp_base = 32'h0800_0000;
        exp_sp = 32'd200;
        applyStimulus(8'h03, 32'd200);
        applyStimulus(8'h02, 32'h0800_0000);
        waitBurst("wb200", 1000);
        checkOutput("wb200_beats", 32'(last_beats), 32'd200);
        checkOutput("wb200_first", first_addr, 32'h0800_0190);
        checkOutput("wb200_last", last_addr, 32'h0800_031E);
        checkOutput("wb200_write_low", 32'(bus.m1_write), 32'd0);
        readRegister(8'h11, rd);
        checkOutput("wb200_start_pixel", rd, 32'd200);
        readRegister(8'h10, rd);
        checkOutput("wb200_counter", rd, 32'd3);
        readRegister(8'h0f, rd);
        checkOutput("wb200_status", rd, 32'h0001_0000);

        $display("[TB] clipped span at pixel 76700");
        exp_base = 32'h0;
        exp_sp = 32'd76700;
        applyStimulus(8'h03, 32'd76700);
        applyStimulus(8'h02, 32'h0);
        waitBurst("wbclip", 1000);
        checkOutput("wbclip_beats", 32'(last_beats), 32'd100);
        checkOutput("wbclip_first", first_addr, 32'h0002_5738);
        checkOutput("wbclip_last", last_addr, 32'h0002_57FE);
        readRegister(8'h10, rd);
        checkOutput("wbclip_counter", rd, 32'd5);
        readRegister(8'h0f, rd);
        checkOutput("wbclip_status", rd, 32'h0001_0000);

        $display("[TB] FIFO overflow");
        auto_done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            bus.s1_address   = 8'h00;
            bus.s1_writedata = 32'(i);
            bus.s1_write     = 1'b1;
        end
        @(negedge clock);
        bus.s1_write = 1'b0;
        readRegister(8'h0f, rd);
        checkOutput("ovf_full_status", rd, 32'h0000_0801);
        applyStimulus(8'h00, 32'hDEAD);
        checkOutput("ovf_irq", 32'(bus.irq), 32'd1);
        readRegister(8'h0f, rd);
        checkOutput("ovf_status", rd, 32'h0001_080B);
        applyStimulus(8'h0e, 32'h3);
        readRegister(8'h0f, rd);
        checkOutput("ovf_cleared_status", rd, 32'h0);
        checkOutput("ovf_cleared_irq", 32'(bus.irq), 32'd0);

        $display("[TB] watchdog timeout");
        applyStimulus(8'h01, 32'd7);
        @(negedge clock);
        checkOutput("wd_start", 32'(bus.op_start), 32'd1);
        checkOutput("wd_code", 32'(bus.op_code), 32'd1);
        checkOutput("wd_arg", bus.op_arg, 32'd7);
        repeat (16) @(negedge clock);
        checkOutput("wd_before_limit", 32'(bus.irq), 32'd0);
        @(negedge clock);
        checkOutput("wd_at_limit", 32'(bus.irq), 32'd1);
        readRegister(8'h0f, rd);
        checkOutput("wd_status", rd, 32'h0001_000F);
        applyStimulus(8'h0e, 32'h3);

        $display("[TB] op_error beats op_done");
        applyStimulus(8'h01, 32'd9);
        @(negedge clock);
        checkOutput("operr_start", 32'(bus.op_start), 32'd1);
        @(negedge clock);
        man_done = 1'b1;
        bus.op_error = 1'b1;
        @(negedge clock);
        man_done = 1'b0;
        bus.op_error = 1'b0;
        readRegister(8'h0f, rd);
        checkOutput("operr_status", rd, 32'h0001_0007);
        readRegister(8'h10, rd);
        checkOutput("operr_counter", rd, 32'd5);
        applyStimulus(8'h0e, 32'h3);

        $display("[TB] reset during burst");
        auto_done = 1'b1;
        exp_base = 32'h0000_1000;
        exp_sp = 32'd0;
        applyStimulus(8'h03, 32'd0);
        applyStimulus(8'h02, 32'h0000_1000);
        for (int i = 0; i < 300 && !(bus.m1_write && beat >= 20); i++) @(negedge clock);
        checkOutput("rstb_burst_active", 32'(bus.m1_write), 32'd1);
        #2 reset_n = 1'b0;
        #1 checkOutput("rstb_write_drop", 32'(bus.m1_write), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        readRegister(8'h0f, rd);
        checkOutput("rstb_status", rd, 32'h0);
        readRegister(8'h10, rd);
        checkOutput("rstb_counter", rd, 32'h0);
        readRegister(8'h11, rd);
        checkOutput("rstb_start_pixel", rd, 32'h0);
        checkOutput("rstb_irq", 32'(bus.irq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
